// File: rtl/shared_dmem_arbiter.sv
// shared_dmem_arbiter: round-robin sharing of one data-memory port among NUM_CORES cores,
// plus end-of-process aggregation. Define ARB_STATS_EN to add saturating grant/stall counters.
module shared_dmem_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MEM_LAT   = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CORES-1:0]        req,
    input  logic [NUM_CORES-1:0]        we,
    input  logic [NUM_CORES*ADDR_W-1:0] addr,
    input  logic [NUM_CORES*DATA_W-1:0] wdata,
    output logic [NUM_CORES-1:0]        ack,
    output logic [DATA_W-1:0]           rdata,
    output logic                        mem_en,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata,
    input  logic [NUM_CORES-1:0]        core_end,
`ifdef ARB_STATS_EN
    output logic [15:0]                 stat_grants,
    output logic [15:0]                 stat_stall,
`endif
    output logic                        busy,
    output logic                        all_end
);

    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CORES - 1);
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        ACK
    } state_t;

    state_t               state;
    state_t               next_state;
    logic [IDX_W-1:0]     gidx;
    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     win_idx;
    logic [IDX_W-1:0]     cand;
    logic                 win_found;
    logic [CNT_W-1:0]     lat_cnt;
    logic [NUM_CORES-1:0] end_seen;

    logic [ADDR_W-1:0] addr_a  [NUM_CORES];
    logic [DATA_W-1:0] wdata_a [NUM_CORES];

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_unpack
        assign addr_a[i]  = addr[i*ADDR_W +: ADDR_W];
        assign wdata_a[i] = wdata[i*DATA_W +: DATA_W];
    end

    // Index base+offs wrapped into 0..NUM_CORES-1; offs never exceeds NUM_CORES.
    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int offs);
        int sum;
        sum = int'(base) + offs;
        if (sum >= NUM_CORES) sum = sum - NUM_CORES;
        return IDX_W'(sum);
    endfunction

    // Search starts just past the last winner, so the previous grantee is checked last.
    always_comb begin
        // NOTE: every variable gets a default before any branch, otherwise a latch is inferred.
        win_idx   = '0;
        win_found = 1'b0;
        cand      = '0;
        for (int k = 1; k <= NUM_CORES; k++) begin
            cand = wrap_idx(rr_ptr, k);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        ack        = '0;
        busy       = (state != IDLE);
        unique case (state)
            IDLE:    if (win_found) next_state = ISSUE;
            ISSUE:   next_state = mem_we ? ACK : WAIT;
            WAIT:    if (lat_cnt == '0) next_state = ACK;
            ACK: begin
                ack[gidx]  = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // mem_en/mem_we default low so the strobes cover exactly the ISSUE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            gidx      <= '0;
            rr_ptr    <= LAST_IDX;
            lat_cnt   <= '0;
            rdata     <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        gidx      <= win_idx;
                        rr_ptr    <= win_idx;
                        mem_en    <= 1'b1;
                        mem_we    <= we[win_idx];
                        mem_addr  <= addr_a[win_idx];
                        mem_wdata <= wdata_a[win_idx];
                    end
                end
                ISSUE: lat_cnt <= LAT_LOAD;
                WAIT: begin
                    if (lat_cnt == '0) rdata <= mem_rdata;
                    else               lat_cnt <= lat_cnt - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // all_end looks at the incoming pulses too, so it rises one cycle after the final pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            end_seen <= '0;
            all_end  <= 1'b0;
        end else begin
            end_seen <= end_seen | core_end;
            all_end  <= &(end_seen | core_end);
        end
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_grants <= '0;
            stat_stall  <= '0;
        end else begin
            if (state == ACK && stat_grants != 16'hFFFF) stat_grants <= stat_grants + 16'd1;
            if ((req & ~ack) != '0 && stat_stall != 16'hFFFF) stat_stall <= stat_stall + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_shared_dmem_arbiter.sv
// Bench for shared_dmem_arbiter: expected grants queued at stimulus time and
// matched against each ack pulse; a behavioural memory answers the port.
module tb_shared_dmem_arbiter;

    localparam int NC  = 4;
    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int LAT = 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [NC-1:0]     req;
    logic [NC-1:0]     we;
    logic [NC*AW-1:0]  addr;
    logic [NC*DW-1:0]  wdata;
    logic [NC-1:0]     ack;
    logic [DW-1:0]     rdata;
    logic              mem_en;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata;
    logic [NC-1:0]     core_end;
    logic              busy;
    logic              all_end;
`ifdef ARB_STATS_EN
    logic [15:0]       stat_grants;
    logic [15:0]       stat_stall;
`endif

    always #5 clk = ~clk;

    shared_dmem_arbiter #(
        .NUM_CORES(NC),
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .MEM_LAT  (LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .we         (we),
        .addr       (addr),
        .wdata      (wdata),
        .ack        (ack),
        .rdata      (rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .core_end   (core_end),
`ifdef ARB_STATS_EN
        .stat_grants(stat_grants),
        .stat_stall (stat_stall),
`endif
        .busy       (busy),
        .all_end    (all_end)
    );

    typedef struct {
        int          core;
        bit          we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
    } sb_t;

    sb_t         sb_q[$];
    int          ack_cyc_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          hold_cnt [NC];
    logic [15:0] mem_model [256];
    int          rd_cnt;
    logic [15:0] rd_data;
    int          t0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: advance to the next falling edge, run the memory and the ack monitor.
    task automatic tick();
        sb_t e;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        mem_rdata = 16'hDEAD;
        if (rd_cnt > 0) begin
            rd_cnt--;
            if (rd_cnt == 0) mem_rdata = rd_data;
        end
        if (mem_en === 1'b1) begin
            if (mem_we === 1'b1) mem_model[mem_addr[7:0]] = mem_wdata;
            else begin
                rd_cnt  = LAT;
                rd_data = mem_model[mem_addr[7:0]];
            end
        end
        if (mem_we === 1'b1) check("mem_we_needs_en", 32'(mem_en), 32'd1);
        if (ack !== '0) begin
            ack_cyc_q.push_back(cyc);
            if (sb_q.size() == 0) check("unexpected_ack", 32'(ack), 32'd0);
            else begin
                e = sb_q.pop_front();
                check("ack_core", 32'(ack), 32'd1 << e.core);
                if (e.we) check("write_landed", 32'(mem_model[e.addr[7:0]]), 32'(e.wdata));
                else      check("read_data", 32'(rdata), 32'(e.rdata));
            end
            for (int i = 0; i < NC; i++) begin
                if (ack[i] === 1'b1) begin
                    if (hold_cnt[i] > 0) hold_cnt[i]--;
                    else                 req[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic drive_core(input int c, input bit w, input logic [15:0] a,
                              input logic [15:0] d, input int hold);
        we[c]            = w;
        addr[c*AW +: AW] = a;
        wdata[c*DW +: DW] = d;
        hold_cnt[c]      = hold;
        req[c]           = 1'b1;
    endtask

    task automatic expect_grant(input int c, input bit w, input logic [15:0] a, input logic [15:0] d);
        sb_t e;
        e.core  = c;
        e.we    = w;
        e.addr  = a;
        e.wdata = d;
        e.rdata = mem_model[a[7:0]];
        sb_q.push_back(e);
    endtask

    task automatic apply_reset();
        rst      = 1'b1;
        req      = '0;
        core_end = '0;
        rd_cnt   = 0;
        sb_q.delete();
        ack_cyc_q.delete();
        foreach (hold_cnt[i]) hold_cnt[i] = 0;
        tick();
        rst = 1'b0;
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || req != '0) && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_drained"}, 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        req       = '0;
        we        = '0;
        addr      = '0;
        wdata     = '0;
        core_end  = '0;
        mem_rdata = 16'hDEAD;
        rd_cnt    = 0;
        rd_data   = '0;
        foreach (hold_cnt[i]) hold_cnt[i] = 0;
        for (int i = 0; i < 256; i++) mem_model[i] = 16'(i * 257) ^ 16'h5A5A;
        mem_model[8'h20] = 16'h1234;

        tick();
        tick();
        check("rst_ack",       32'(ack),       32'd0);
        check("rst_rdata",     32'(rdata),     32'd0);
        check("rst_mem_en",    32'(mem_en),    32'd0);
        check("rst_mem_we",    32'(mem_we),    32'd0);
        check("rst_mem_addr",  32'(mem_addr),  32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_all_end",   32'(all_end),   32'd0);
        rst = 1'b0;

        // Single write from core 0.
        drive_core(0, 1'b1, 16'h0010, 16'hBEEF, 0);
        expect_grant(0, 1'b1, 16'h0010, 16'hBEEF);
        tick();
        check("wr_mem_en",    32'(mem_en),    32'd1);
        check("wr_mem_we",    32'(mem_we),    32'd1);
        check("wr_mem_addr",  32'(mem_addr),  32'h0010);
        check("wr_mem_wdata", 32'(mem_wdata), 32'hBEEF);
        check("wr_early_ack", 32'(ack),       32'd0);
        tick();
        check("wr_ack",       32'(ack),       32'b0001);
        check("wr_ack_strobe_low", 32'(mem_en), 32'd0);
        drain("single_write", 20);

        // Single read from core 2.
        tick();
        drive_core(2, 1'b0, 16'h0020, 16'h0000, 0);
        expect_grant(2, 1'b0, 16'h0020, 16'h0000);
        tick();
        check("rd_mem_en",   32'(mem_en),   32'd1);
        check("rd_mem_we",   32'(mem_we),   32'd0);
        check("rd_mem_addr", 32'(mem_addr), 32'h0020);
        tick();
        check("rd_wait_ack",   32'(ack),      32'd0);
        check("rd_wait_busy",  32'(busy),     32'd1);
        check("rd_wait_en",    32'(mem_en),   32'd0);
        check("rd_addr_holds", 32'(mem_addr), 32'h0020);
        tick();
        check("rd_ack",   32'(ack),   32'b0100);
        check("rd_rdata", 32'(rdata), 32'h1234);
        drain("single_read", 20);

        // All four cores write at once from reset.
        apply_reset();
        t0 = cyc;
        for (int i = 0; i < NC; i++) begin
            drive_core(i, 1'b1, 16'h0050 + 16'(i), 16'hA000 + 16'(i), 0);
            expect_grant(i, 1'b1, 16'h0050 + 16'(i), 16'hA000 + 16'(i));
        end
        drain("all_four", 40);
        check("all_four_ack_count", 32'(ack_cyc_q.size()), 32'd4);
        if (ack_cyc_q.size() > 0) check("all_four_first_lat", 32'(ack_cyc_q[0] - t0), 32'd2);
        for (int i = 1; i < ack_cyc_q.size(); i++)
            check("all_four_spacing", 32'(ack_cyc_q[i] - ack_cyc_q[i-1]), 32'd3);

        // Core 1 holds its read request while core 3 asks once.
        apply_reset();
        drive_core(1, 1'b0, 16'h0030, 16'h0000, 2);
        drive_core(3, 1'b1, 16'h0031, 16'h3333, 0);
        expect_grant(1, 1'b0, 16'h0030, 16'h0000);
        expect_grant(3, 1'b1, 16'h0031, 16'h3333);
        expect_grant(1, 1'b0, 16'h0030, 16'h0000);
        expect_grant(1, 1'b0, 16'h0030, 16'h0000);
        drain("fairness", 60);

        // Reset lands in the read wait cycle of core 0.
        apply_reset();
        drive_core(0, 1'b0, 16'h0040, 16'h0000, 0);
        tick();
        tick();
        check("mid_wait_busy", 32'(busy), 32'd1);
        check("mid_wait_ack",  32'(ack),  32'd0);
        apply_reset();
        check("abort_ack",    32'(ack),      32'd0);
        check("abort_mem_en", 32'(mem_en),   32'd0);
        check("abort_busy",   32'(busy),     32'd0);
        check("abort_rdata",  32'(rdata),    32'd0);
        check("abort_addr",   32'(mem_addr), 32'd0);
        t0 = cyc;
        drive_core(0, 1'b0, 16'h0040, 16'h0000, 0);
        drive_core(1, 1'b1, 16'h0041, 16'h4141, 0);
        expect_grant(0, 1'b0, 16'h0040, 16'h0000);
        expect_grant(1, 1'b1, 16'h0041, 16'h4141);
        drain("after_abort", 40);
        if (ack_cyc_q.size() > 0) check("after_abort_rd_lat", 32'(ack_cyc_q[0] - t0), 32'(2 + LAT));

        // End aggregation.
        tick();
        core_end = 4'b0001;
        tick();
        core_end = '0;
        check("end_partial1", 32'(all_end), 32'd0);
        tick();
        core_end = 4'b0100;
        tick();
        core_end = '0;
        tick();
        check("end_partial2", 32'(all_end), 32'd0);
        core_end = 4'b1010;
        check("end_same_cycle", 32'(all_end), 32'd0);
        tick();
        core_end = '0;
        check("end_rise", 32'(all_end), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("end_sticky", 32'(all_end), 32'd1);
        end
        drive_core(2, 1'b1, 16'h0060, 16'h6066, 0);
        expect_grant(2, 1'b1, 16'h0060, 16'h6066);
        drain("serve_after_end", 20);
        check("end_still_high", 32'(all_end), 32'd1);
        apply_reset();
        check("end_cleared", 32'(all_end), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shared_dmem_arbiter.md
Name: shared_dmem_arbiter

Overview:
- Round-robin arbiter that shares one data-memory port between NUM_CORES processor cores.
- Each core's control unit raises a request. The arbiter serialises accesses, drives the single memory port, and returns a one-cycle ack with read data.
- It also aggregates each core's end_process into one all_end flag for the top level.

Parameters:
- NUM_CORES, 4, number of requesting cores (2..8)
- ADDR_W, 16, memory address width
- DATA_W, 16, memory data width
- MEM_LAT, 1, read latency in cycles from mem_en to valid mem_rdata (>=1)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  NUM_CORES  per-core access request, held until ack
- we  in  NUM_CORES  per-core write enable, qualifies req
- addr  in  NUM_CORES*ADDR_W  packed per-core addresses, core i at [i*ADDR_W +: ADDR_W]
- wdata  in  NUM_CORES*DATA_W  packed per-core write data
- ack  out  NUM_CORES  one-hot, one-cycle completion pulse
- rdata  out  DATA_W  read data, valid while ack is high (shared by all cores)
- mem_en  out  1  memory access strobe, one cycle per access
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- core_end  in  NUM_CORES  per-core end_process
- busy  out  1  high in any state other than IDLE
- all_end  out  1  high once every core has asserted core_end

Behaviour:
- Reset values: ack=0, rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, all_end=0, sticky end bits=0, rr_ptr=NUM_CORES-1 (core 0 wins first), state=IDLE.
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - If any req is high, select the winner by searching from rr_ptr+1 upward, modulo NUM_CORES.
  - Register winner index into gidx and rr_ptr.
  - Register the winner's addr, we and wdata onto the mem_* outputs.
  - Go to ISSUE.
- ISSUE:
  - mem_en=1 and mem_we=we[gidx] for this one cycle only.
  - Write: go to ACK.
  - Read: go to WAIT with the latency counter set to MEM_LAT-1.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter is 0, register mem_rdata into rdata and go to ACK.
  - WAIT therefore lasts exactly MEM_LAT cycles.
- ACK: ack[gidx]=1 for one cycle, then go to IDLE.
- Latency, with req first high in cycle t (state IDLE):
  - Write: mem_en in t+1, ack in t+2.
  - Read: mem_en in t+1, ack in t+2+MEM_LAT.
- Handshake: a core keeps req, we, addr and wdata stable until it samples ack, then drops req on the next edge. A core that keeps req high re-arbitrates fairly; it never wins twice in a row while another core is requesting.
- mem_addr and mem_wdata hold their last values outside ISSUE. mem_we is high only while mem_en is high.
- A core dropping req before ack is a protocol violation: the access still completes and ack still pulses.
- Simultaneous requests are resolved purely by round-robin. No request is lost while req stays high.
- Reset mid-access: the in-flight access is abandoned, no ack is issued, all outputs return to reset values on that edge, and state returns to IDLE.
- End aggregation:
  - Sticky bit i sets on any cycle where core_end[i]=1 and clears only on rst.
  - all_end is registered: it goes high the cycle after the last sticky bit sets.
- The arbiter keeps serving requests after all_end.

Optional Feature:
- Macro: ARB_STATS_EN.
- Defined:
  - Adds output stat_grants (16 bits), which increments on every ACK cycle and saturates at 0xFFFF.
  - Adds output stat_stall (16 bits), which increments, saturating, on every cycle where req has a bit set that is not receiving ack.
  - Both counters reset to 0.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Single write: req=0001, we=0001, addr0=0x0010, wdata0=0xBEEF at t -> mem_en=1, mem_we=1, mem_addr=0x0010, mem_wdata=0xBEEF in t+1; ack=0001 in t+2.
- Single read, MEM_LAT=1: core 2 reads 0x0020 while memory returns 0x1234 -> mem_en in t+1, ack=0100 with rdata=0x1234 in t+3.
- All four cores request from reset and hold req until ack -> ack order 0,1,2,3; consecutive grants 3 cycles apart for writes.
- Core 1 holds req continuously while core 3 requests once -> grant order 1,3,1,1; no double grant to core 1 while core 3 waits.
- rst pulsed in a WAIT cycle -> no ack, mem_en=0, busy=0 after the edge; a new req is then served normally with core 0 first.
- core_end pulses 0001, 0100, 1010 on separate cycles -> all_end rises the cycle after the 1010 pulse and stays high until rst.
